// File: rtl/alu_operand_issue.sv
// ID->EX operand issue stage: one registered EX slot, operand select/bypass, MUL multi-cycle hold.
// Optional macro FORWARDING_EN enables EX/WB bypass; otherwise decode stalls on register hazards.
`ifndef ADD
`define ADD 4'd0
`endif
`ifndef SUB
`define SUB 4'd1
`endif
`ifndef MUL
`define MUL 4'd2
`endif

module alu_operand_issue #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [DATA_W-1:0] id_rs1_val,
  input  logic [DATA_W-1:0] id_rs2_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  output logic [3:0]        ex_op,
  output logic [DATA_W-1:0] ex_x,
  output logic [DATA_W-1:0] ex_y,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_we,
  output logic              ex_valid,
  output logic              ex_done,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_ready,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {EMPTY, EXEC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              retire;
  logic              issue;
  logic              hazard_stall;
  logic              we_sel;
  logic [DATA_W-1:0] x_sel;
  logic [DATA_W-1:0] y_sel;

  assign ex_valid = (state != EMPTY);
  assign ex_done  = (state == DONE);
  assign retire   = (state == DONE) && mem_ready && !reset;
  assign id_ready = !reset && ((state == EMPTY) || retire) && !hazard_stall;
  assign issue    = id_valid && id_ready;
  assign we_sel   = ((id_op == `ADD) || (id_op == `SUB) || (id_op == `MUL)) && (id_rd != '0);

`ifdef FORWARDING_EN
  // EX bypass only applies while the EX instruction is retiring; it outranks WB.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] rs_val,
    input logic              ex_hit_en,
    input logic [REG_AW-1:0] ex_dst,
    input logic [DATA_W-1:0] ex_val,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_dst,
    input logic [DATA_W-1:0] wb_val
  );
    if (rs == '0)                        return '0;
    else if (ex_hit_en && ex_dst == rs)  return ex_val;
    else if (wb_en && wb_dst == rs)      return wb_val;
    else                                 return rs_val;
  endfunction

  assign hazard_stall = 1'b0;

  always_comb begin
    x_sel = fwd(id_rs1, id_rs1_val, retire && ex_we, ex_rd, ex_result, wb_valid, wb_rd, wb_data);
    y_sel = id_use_imm ? id_imm
                       : fwd(id_rs2, id_rs2_val, retire && ex_we, ex_rd, ex_result, wb_valid, wb_rd, wb_data);
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{ex_result, wb_data};

  function automatic logic src_hit(
    input logic [REG_AW-1:0] rs,
    input logic              ex_live,
    input logic [REG_AW-1:0] ex_dst,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_dst
  );
    return (rs != '0) && ((ex_live && rs == ex_dst) || (wb_en && rs == wb_dst));
  endfunction

  always_comb begin
    hazard_stall = src_hit(id_rs1, ex_valid && ex_we, ex_rd, wb_valid, wb_rd) ||
                   (!id_use_imm && src_hit(id_rs2, ex_valid && ex_we, ex_rd, wb_valid, wb_rd));
    x_sel = (id_rs1 == '0) ? '0 : id_rs1_val;
    y_sel = id_use_imm ? id_imm : ((id_rs2 == '0) ? '0 : id_rs2_val);
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      EXEC: begin
        if (cnt == CNT_W'(1)) state_nxt = DONE;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      default: ;
    endcase
    // Retire frees the slot; a same-cycle issue then refills it without a bubble.
    if (retire) state_nxt = EMPTY;
    if (issue) begin
      if ((id_op == `MUL) && (MUL_LAT != 0)) begin
        state_nxt = EXEC;
        cnt_nxt   = CNT_W'(MUL_LAT);
      end else begin
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      cnt   <= '0;
      ex_op <= '0;
      ex_x  <= '0;
      ex_y  <= '0;
      ex_rd <= '0;
      ex_we <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (issue) begin
        ex_op <= id_op;
        ex_x  <= x_sel;
        ex_y  <= y_sel;
        ex_rd <= id_rd;
        ex_we <= we_sel;
      end else if (retire) begin
        ex_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue: directed scenarios then random traffic vs a slot-level model.
`ifndef ADD
`define ADD 4'd0
`endif
`ifndef SUB
`define SUB 4'd1
`endif
`ifndef MUL
`define MUL 4'd2
`endif

module tb_alu_operand_issue;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;

  logic          clk, reset, id_valid, id_ready, id_use_imm;
  logic          ex_we, ex_valid, ex_done, mem_ready, wb_valid;
  logic [3:0]    id_op, ex_op;
  logic [AW-1:0] id_rd, id_rs1, id_rs2, ex_rd, wb_rd;
  logic [DW-1:0] id_rs1_val, id_rs2_val, id_imm, ex_x, ex_y, ex_result, wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Slot model: occupancy, cycles still to wait before the result is final, and the issued fields.
  bit            m_busy;
  int            m_left;
  logic [3:0]    m_op;
  logic [DW-1:0] m_x, m_y;
  logic [AW-1:0] m_rd;
  bit            m_we;
  bit            accepted;

  alu_operand_issue #(.DATA_W(DW), .REG_AW(AW), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .ex_op(ex_op), .ex_x(ex_x), .ex_y(ex_y), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_valid(ex_valid), .ex_done(ex_done), .ex_result(ex_result), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes_reg(input logic [3:0] op, input logic [AW-1:0] rd);
    return ((op == `ADD) || (op == `SUB) || (op == `MUL)) && (rd != 0);
  endfunction

  function automatic bit slot_retiring();
    return !reset && m_busy && (m_left == 0) && mem_ready;
  endfunction

  function automatic bit blocks(input logic [AW-1:0] rs);
`ifdef FORWARDING_EN
    return 1'b0 && (rs != 0);
`else
    if (rs == 0) return 1'b0;
    return (m_busy && m_we && m_rd == rs) || (wb_valid && wb_rd == rs);
`endif
  endfunction

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] rs, input logic [DW-1:0] val);
    if (rs == 0) return '0;
`ifdef FORWARDING_EN
    if (slot_retiring() && m_we && m_rd == rs) return ex_result;
    if (wb_valid && wb_rd == rs) return wb_data;
`endif
    return val;
  endfunction

  function automatic bit model_ready();
    bit stall;
    stall = blocks(id_rs1) || (!id_use_imm && blocks(id_rs2));
    return !reset && (!m_busy || (m_left == 0 && mem_ready)) && !stall;
  endfunction

  task automatic step();
    bit rdy, iss, ret;
    logic [DW-1:0] nx, ny;
    @(negedge clk);
    rdy = model_ready();
    check("ex_valid", ex_valid, m_busy);
    check("ex_done", ex_done, m_busy && m_left == 0);
    check("ex_we", ex_we, m_we);
    check("ex_op", ex_op, m_op);
    check("ex_x", ex_x, m_x);
    check("ex_y", ex_y, m_y);
    check("ex_rd", ex_rd, m_rd);
    check("id_ready", id_ready, rdy);
    ret = slot_retiring();
    iss = id_valid && rdy;
    nx  = operand(id_rs1, id_rs1_val);
    ny  = id_use_imm ? id_imm : operand(id_rs2, id_rs2_val);
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_left = 0; m_op = '0; m_x = '0; m_y = '0; m_rd = '0; m_we = 0;
    end else begin
      if (m_busy && m_left > 0) m_left--;
      if (ret && !iss) begin
        m_busy = 0;
        m_we   = 0;
      end
      if (iss) begin
        m_busy = 1;
        m_left = (id_op == `MUL) ? int'(LAT) : 0;
        m_op   = id_op;
        m_x    = nx;
        m_y    = ny;
        m_rd   = id_rd;
        m_we   = writes_reg(id_op, id_rd);
      end
    end
    accepted = iss;
    #1;
  endtask

  task automatic present(input logic [3:0] op, input int rd, input int rs1, input logic [DW-1:0] v1,
                         input int rs2, input logic [DW-1:0] v2);
    id_valid = 1; id_op = op; id_rd = AW'(rd); id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
    id_rs1_val = v1; id_rs2_val = v2; id_imm = '0; id_use_imm = 0;
  endtask

  initial begin
    int waited;
    m_busy = 0; m_left = 0; m_op = '0; m_x = '0; m_y = '0; m_rd = '0; m_we = 0; accepted = 0;
    reset = 1; id_valid = 0; id_op = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_val = '0; id_rs2_val = '0; id_imm = '0; id_use_imm = 0;
    ex_result = '0; mem_ready = 1; wb_valid = 0; wb_rd = '0; wb_data = '0;

    // 1: reset held two cycles
    step(); step();
    reset = 0;
    #1;
    check("t1_ready", id_ready, 1);
    check("t1_valid", ex_valid, 0);
    check("t1_done", ex_done, 0);
    check("t1_x", ex_x, 0);

    // 2: plain ADD
    present(`ADD, 4, 1, 5, 2, 7);
    step();
    id_valid = 0;
    check("t2_op", ex_op, `ADD);
    check("t2_x", ex_x, 5);
    check("t2_y", ex_y, 7);
    check("t2_done", ex_done, 1);

    // 3: MUL followed by a waiting ADD
    present(`MUL, 5, 1, 3, 2, 4);
    step();
    present(`ADD, 6, 1, 5, 2, 7);
    waited = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      waited = k;
      if (accepted) break;
    end
    check("t3_mul_wait", waited, LAT + 1);
    id_valid = 0;
    check("t3_no_bubble_valid", ex_valid, 1);
    check("t3_no_bubble_op", ex_op, `ADD);

    // 4: dependent SUB on r3
    present(`ADD, 3, 1, 5, 2, 7);
    step();
    present(`SUB, 7, 3, 0, 1, 5);
    ex_result = 12;
    step();
`ifdef FORWARDING_EN
    check("t4_nostall", accepted, 1);
    check("t4_x", ex_x, 12);
    check("t4_y", ex_y, 5);
    id_valid = 0;
`else
    check("t4_stall_ex", accepted, 0);
    wb_valid = 1; wb_rd = 3; wb_data = 12;
    step();
    check("t4_stall_wb", accepted, 0);
    wb_valid = 0; id_rs1_val = 12;
    step();
    check("t4_issue", accepted, 1);
    check("t4_x", ex_x, 12);
    check("t4_y", ex_y, 5);
    id_valid = 0;
`endif
    step();

    // 5: backpressure, and rs1=0 never forwarded while ex_rd=0
    present(`ADD, 0, 2, 9, 2, 9);
    step();
    mem_ready = 0;
    ex_result = 32'hAB;
    present(`ADD, 4, 0, 32'h55, 2, 9);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_hold_accept", accepted, 0);
      check("t5_hold_x", ex_x, 9);
      check("t5_hold_done", ex_done, 1);
    end
    mem_ready = 1;
    step();
    check("t5_retire_issue", accepted, 1);
    check("t5_zero_src", ex_x, 0);
    id_valid = 0;
    step();

    // 6: reset during MUL cycle 2
    present(`MUL, 5, 1, 3, 2, 4);
    step();
    id_valid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    #1;
    check("t6_valid", ex_valid, 0);
    check("t6_done", ex_done, 0);
    check("t6_ready", id_ready, 1);
    for (int k = 0; k < LAT + 2; k++) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!(id_valid && !accepted)) begin
        id_valid   = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0, 1:    id_op = `ADD;
          2:       id_op = `SUB;
          3:       id_op = `MUL;
          4:       id_op = 4'd9;
          default: id_op = 4'hF;
        endcase
        id_rd      = AW'($urandom_range(0, 3));
        id_rs1     = AW'($urandom_range(0, 3));
        id_rs2     = AW'($urandom_range(0, 3));
        id_rs1_val = $urandom;
        id_rs2_val = $urandom;
        id_imm     = $urandom;
        id_use_imm = ($urandom_range(0, 2) == 0);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 3) == 0);
      wb_rd     = AW'($urandom_range(0, 3));
      wb_data   = $urandom;
      ex_result = $urandom;
      reset     = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
